// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among execution units and a
// one-cycle registered broadcast of the winner's tag, data and ROB id.
module cdb_arbiter #(
  parameter int NUM_EXU   = 4,
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_EXU-1:0]             exu_req,
  output logic [NUM_EXU-1:0]             exu_rdy,
  input  logic [NUM_EXU*TAG_W-1:0]       exu_tag,
  input  logic [NUM_EXU*32-1:0]          exu_wdata,
  input  logic [NUM_EXU*ROB_PTR_W-1:0]   exu_inst_id,
  output logic                           cdb_wr,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [31:0]                    cdb_wdata,
  output logic [ROB_PTR_W-1:0]           cdb_inst_id
);

  localparam int RR_W = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 cdb_wr_q, cdb_wr_d;
  logic [TAG_W-1:0]     cdb_tag_q, cdb_tag_d;
  logic [31:0]          cdb_wdata_q, cdb_wdata_d;
  logic [ROB_PTR_W-1:0] cdb_inst_id_q, cdb_inst_id_d;

  logic                 grant_found;
  logic [RR_W-1:0]      grant_idx;
  logic [RR_W-1:0]      cand_idx;
  logic [NUM_EXU-1:0]   grant;

  // Rotating priority search; depends only on req, pointer, flush and reset.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_EXU; k++) begin
        cand_idx = RR_W'((int'(rr_ptr_q) + k) % NUM_EXU);
        if (!grant_found && exu_req[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
      if (grant_found) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    cdb_wr_d      = grant_found;
    cdb_tag_d     = cdb_tag_q;
    cdb_wdata_d   = cdb_wdata_q;
    cdb_inst_id_d = cdb_inst_id_q;
    if (grant_found) begin
      rr_ptr_d      = (grant_idx == RR_W'(NUM_EXU - 1)) ? '0 : grant_idx + RR_W'(1);
      cdb_tag_d     = exu_tag[int'(grant_idx)*TAG_W +: TAG_W];
      cdb_wdata_d   = exu_wdata[int'(grant_idx)*32 +: 32];
      cdb_inst_id_d = exu_inst_id[int'(grant_idx)*ROB_PTR_W +: ROB_PTR_W];
    end
    if (flush) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      cdb_wr_q      <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_wdata_q   <= '0;
      cdb_inst_id_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_wr_q      <= cdb_wr_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_wdata_q   <= cdb_wdata_d;
      cdb_inst_id_q <= cdb_inst_id_d;
    end
  end

  assign exu_rdy     = grant;
  assign cdb_wr      = cdb_wr_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_wdata   = cdb_wdata_q;
  assign cdb_inst_id = cdb_inst_id_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a per-cycle reference model plus directed scenarios
// with literal expectations for grants and broadcasts.
module tb_cdb_arbiter;
  localparam int NUM_EXU   = 4;
  localparam int TAG_W     = 4;
  localparam int ROB_PTR_W = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         flush = 1'b0;
  logic [NUM_EXU-1:0]           exu_req = '0;
  logic [NUM_EXU-1:0]           exu_rdy;
  logic [NUM_EXU*TAG_W-1:0]     exu_tag = '0;
  logic [NUM_EXU*32-1:0]        exu_wdata = '0;
  logic [NUM_EXU*ROB_PTR_W-1:0] exu_inst_id = '0;
  logic                         cdb_wr;
  logic [TAG_W-1:0]             cdb_tag;
  logic [31:0]                  cdb_wdata;
  logic [ROB_PTR_W-1:0]         cdb_inst_id;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_EXU(NUM_EXU), .TAG_W(TAG_W), .ROB_DEPTH(16), .ROB_PTR_W(ROB_PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .exu_req(exu_req), .exu_rdy(exu_rdy),
    .exu_tag(exu_tag), .exu_wdata(exu_wdata), .exu_inst_id(exu_inst_id),
    .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata), .cdb_inst_id(cdb_inst_id)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setUnit(input int u, input logic [TAG_W-1:0] tag, input logic [31:0] data,
                         input logic [ROB_PTR_W-1:0] id);
    exu_tag[u*TAG_W +: TAG_W]             = tag;
    exu_wdata[u*32 +: 32]                 = data;
    exu_inst_id[u*ROB_PTR_W +: ROB_PTR_W] = id;
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sampling point.
  task automatic applyStimulus(input logic [NUM_EXU-1:0] req, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    exu_req = req;
    flush   = fl;
    rst     = rs;
    @(negedge clk);
  endtask

  // Reference model: broadcast registers, pointer and the cycle's expected grant.
  int                   m_ptr = 0, n_ptr = 0;
  bit                   m_wr = 1'b0, n_wr = 1'b0;
  logic [TAG_W-1:0]     m_tag = '0, n_tag = '0;
  logic [31:0]          m_data = '0, n_data = '0;
  logic [ROB_PTR_W-1:0] m_id = '0, n_id = '0;
  bit                   m_valid = 1'b0;

  always @(negedge clk) begin
    logic [NUM_EXU-1:0] exp_rdy;
    logic [1:0]         idx;
    int                 w;
    exp_rdy = '0;
    w = -1;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_EXU; k++) begin
        idx = 2'((m_ptr + k) % NUM_EXU);
        if (w < 0 && exu_req[idx]) begin
          w = int'(idx);
          exp_rdy[idx] = 1'b1;
        end
      end
    end
    if (m_valid) begin
      checkOutput("model_rdy", 32'(exu_rdy), 32'(exp_rdy));
      checkOutput("model_wr", 32'(cdb_wr), 32'(m_wr));
      checkOutput("model_tag", 32'(cdb_tag), 32'(m_tag));
      checkOutput("model_data", cdb_wdata, m_data);
      checkOutput("model_id", 32'(cdb_inst_id), 32'(m_id));
    end
    if (rst) begin
      n_ptr = 0; n_wr = 1'b0; n_tag = '0; n_data = '0; n_id = '0;
    end else begin
      n_ptr = m_ptr; n_wr = (w >= 0); n_tag = m_tag; n_data = m_data; n_id = m_id;
      if (w >= 0) begin
        n_ptr  = (w + 1) % NUM_EXU;
        n_tag  = exu_tag[w*TAG_W +: TAG_W];
        n_data = exu_wdata[w*32 +: 32];
        n_id   = exu_inst_id[w*ROB_PTR_W +: ROB_PTR_W];
      end
      if (flush) n_ptr = 0;
    end
  end

  always @(posedge clk) begin
    m_ptr  <= n_ptr;
    m_wr   <= n_wr;
    m_tag  <= n_tag;
    m_data <= n_data;
    m_id   <= n_id;
    if (rst) m_valid <= 1'b1;
  end

  initial begin
    for (int i = 0; i < NUM_EXU; i++)
      setUnit(i, TAG_W'(i + 8), 32'hA000_0000 + 32'(i), ROB_PTR_W'(i + 1));

    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("rdy_in_reset", 32'(exu_rdy), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("reset_wr", 32'(cdb_wr), 32'h0);
    checkOutput("reset_tag", 32'(cdb_tag), 32'h0);
    checkOutput("reset_data", cdb_wdata, 32'h0);
    checkOutput("reset_id", 32'(cdb_inst_id), 32'h0);

    // Single requester, then probe that the pointer advanced to 3.
    setUnit(2, 4'd3, 32'hDEADBEEF, 4'd5);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("single_rdy", 32'(exu_rdy), 32'h4);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("single_wr", 32'(cdb_wr), 32'h1);
    checkOutput("single_tag", 32'(cdb_tag), 32'h3);
    checkOutput("single_data", cdb_wdata, 32'hDEADBEEF);
    checkOutput("single_id", 32'(cdb_inst_id), 32'h5);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("ptr3_probe_rdy", 32'(exu_rdy), 32'h8);
    setUnit(2, 4'd10, 32'hA000_0002, 4'd3);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("reset_drops_wr", 32'(cdb_wr), 32'h0);

    // All units requesting: strict rotation and back-to-back broadcasts.
    for (int c = 0; c < 8; c++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("rr_rdy", 32'(exu_rdy), 32'(1 << (c % 4)));
      if (c > 0) begin
        checkOutput("rr_wr", 32'(cdb_wr), 32'h1);
        checkOutput("rr_tag", 32'(cdb_tag), 32'(8 + ((c - 1) % 4)));
      end
    end
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("rr_last_tag", 32'(cdb_tag), 32'd11);

    // Wrap from pointer 3 back to unit 0.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("wrap_setup_rdy", 32'(exu_rdy), 32'h4);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("wrap_rdy3", 32'(exu_rdy), 32'h8);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("wrap_rdy0", 32'(exu_rdy), 32'h1);
    checkOutput("wrap_tag3", 32'(cdb_tag), 32'd11);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("wrap_ptr1_rdy", 32'(exu_rdy), 32'h2);

    // Unit 1 is served while unit 0 keeps requesting.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("hold_flush_rdy", 32'(exu_rdy), 32'h0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    checkOutput("hold_rdy0", 32'(exu_rdy), 32'h1);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    checkOutput("hold_rdy1", 32'(exu_rdy), 32'h2);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("hold_tag1", 32'(cdb_tag), 32'd9);
    checkOutput("hold_data1", cdb_wdata, 32'hA000_0001);

    // Flush after a grant: the captured result still goes out once.
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("flush_pre_rdy", 32'(exu_rdy), 32'h4);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("flush_rdy", 32'(exu_rdy), 32'h0);
    checkOutput("flush_wr", 32'(cdb_wr), 32'h1);
    checkOutput("flush_tag", 32'(cdb_tag), 32'd10);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("post_flush_wr", 32'(cdb_wr), 32'h0);
    checkOutput("post_flush_rdy", 32'(exu_rdy), 32'h1);

    // Reset in the cycle after a transfer.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("rst_pre_rdy", 32'(exu_rdy), 32'h2);
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("rst_mid_rdy", 32'(exu_rdy), 32'h0);
    checkOutput("rst_mid_wr", 32'(cdb_wr), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("rst_after_wr", 32'(cdb_wr), 32'h0);
    checkOutput("rst_after_data", cdb_wdata, 32'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("rst_regrant_rdy", 32'(exu_rdy), 32'h1);

    // Reset together with flush behaves as plain reset.
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    checkOutput("rstflush_rdy", 32'(exu_rdy), 32'h0);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("rstflush_wr", 32'(cdb_wr), 32'h0);
    checkOutput("rstflush_regrant", 32'(exu_rdy), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
